xeng_corr_apply: RTL and testbench

XENG_CORR_APPLY -- requirements
Module: xeng_corr_apply

---
 rtl/xeng_corr_apply_pkg.sv | 40 ++++
 rtl/xeng_corr_apply_corr_lane.sv | 87 ++++++++
 rtl/xeng_corr_apply.sv | 102 ++++++++++
 tb/tb_xeng_corr_apply.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/xeng_corr_apply_pkg.sv
// Shared derivations and polarisation ordering for the X-engine correction datapath.
package xeng_corr_apply_pkg;

  typedef enum logic [1:0] {
    POL_XX = 2'd0,
    POL_XY = 2'd1,
    POL_YX = 2'd2,
    POL_YY = 2'd3
  } pol_e;

  localparam int N_POLS = 4;

  function automatic int calc_corr_width(input int p_bits, input int s_bits, input int bw);
    return p_bits + s_bits + bw + 3;
  endfunction

  function automatic int calc_k_shift(input int bw);
    return bw - 1;
  endfunction

  function automatic int calc_n_bls(input int n_ants);
    return n_ants * (n_ants / 2 + 1);
  endfunction

  function automatic longint calc_re_const(input int p_bits, input int s_bits, input int bw);
    return -(longint'(1) << (p_bits + s_bits + 2 * (bw - 1)));
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // xx sits in the most significant slice of every packed 4-pol bus
  function automatic int lane_base(input int pol_idx, input int w);
    return (N_POLS - 1 - pol_idx) * w;
  endfunction

endpackage

// File: rtl/xeng_corr_apply_corr_lane.sv
// One polarisation of the correction datapath: re/im correction subtract, re offset, saturation.
module xeng_corr_apply_corr_lane
  import xeng_corr_apply_pkg::*;
#(
  parameter int     ACC_WIDTH  = 32,
  parameter int     CORR_WIDTH = 16,
  parameter int     OUT_WIDTH  = 32,
  parameter int     K_SHIFT    = 3,
  parameter longint RE_CONST   = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en_p0,
  input  logic                         en_p1,
  input  logic                         en_p2,
  input  logic signed [ACC_WIDTH-1:0]  raw_re,
  input  logic signed [ACC_WIDTH-1:0]  raw_im,
  input  logic signed [CORR_WIDTH-1:0] re_corr,
  input  logic signed [CORR_WIDTH-1:0] im_corr,
  output logic signed [OUT_WIDTH-1:0]  dout_re,
  output logic signed [OUT_WIDTH-1:0]  dout_im,
  output logic                         clamp
);

  // Two guard bits keep every intermediate sum exact; nothing wraps before saturation.
  localparam int EW = max3(ACC_WIDTH, CORR_WIDTH + K_SHIFT, OUT_WIDTH) + 2;
  localparam logic signed [EW-1:0] RE_C    = EW'(RE_CONST);
  localparam logic signed [EW-1:0] OUT_MAX = {{(EW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] OUT_MIN = {{(EW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  function automatic logic signed [EW-1:0] ext_acc(input logic signed [ACC_WIDTH-1:0] x);
    return {{(EW-ACC_WIDTH){x[ACC_WIDTH-1]}}, x};
  endfunction

  function automatic logic signed [EW-1:0] ext_corr(input logic signed [CORR_WIDTH-1:0] x);
    return {{(EW-CORR_WIDTH){x[CORR_WIDTH-1]}}, x} << K_SHIFT;
  endfunction

  function automatic logic over_range(input logic signed [EW-1:0] v);
    return (v > OUT_MAX) || (v < OUT_MIN);
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] sat(input logic signed [EW-1:0] v);
    if (v > OUT_MAX) return OUT_MAX[OUT_WIDTH-1:0];
    if (v < OUT_MIN) return OUT_MIN[OUT_WIDTH-1:0];
    return v[OUT_WIDTH-1:0];
  endfunction

  logic signed [EW-1:0] raw_re_p0, raw_im_p0, corr_re_p0, corr_im_p0;
  logic signed [EW-1:0] diff_re_p1, diff_im_p1;
  logic signed [EW-1:0] sum_re;

  // stage 1: widen inputs, pre-shift corrections
  always_ff @(posedge clk) begin
    if (en_p0) begin
      raw_re_p0  <= ext_acc(raw_re);
      raw_im_p0  <= ext_acc(raw_im);
      corr_re_p0 <= ext_corr(re_corr);
      corr_im_p0 <= ext_corr(im_corr);
    end
  end

  // stage 2: subtract corrections
  always_ff @(posedge clk) begin
    if (en_p1) begin
      diff_re_p1 <= raw_re_p0 - corr_re_p0;
      diff_im_p1 <= raw_im_p0 - corr_im_p0;
    end
  end

  // stage 3: real-part offset, saturate, register
  always_comb begin
    sum_re = diff_re_p1 + RE_C;
    clamp  = over_range(sum_re) | over_range(diff_im_p1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_re <= '0;
      dout_im <= '0;
    end else if (en_p2) begin
      dout_re <= sat(sum_re);
      dout_im <= sat(diff_im_p1);
    end
  end

endmodule

// File: rtl/xeng_corr_apply.sv
// Applies component-tracker corrections to raw X-engine accumulations for all four pols.
module xeng_corr_apply
  import xeng_corr_apply_pkg::*;
#(
  parameter int  SERIAL_ACC_LEN_BITS = 7,
  parameter int  P_FACTOR_BITS       = 2,
  parameter int  BITWIDTH            = 4,
  parameter int  N_ANTS              = 32,
  parameter int  ACC_WIDTH           = 32,
  parameter int  OUT_WIDTH           = 32,
  localparam int CORR_WIDTH          = calc_corr_width(P_FACTOR_BITS, SERIAL_ACC_LEN_BITS, BITWIDTH),
  localparam int K_SHIFT             = calc_k_shift(BITWIDTH),
  localparam int N_BLS               = calc_n_bls(N_ANTS),
  localparam int BL_W                = $clog2(N_BLS),
  localparam longint RE_CONST        = calc_re_const(P_FACTOR_BITS, SERIAL_ACC_LEN_BITS, BITWIDTH)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                sync_in,
  input  logic                                din_vld,
  input  logic signed [N_POLS*ACC_WIDTH-1:0]  raw_re,
  input  logic signed [N_POLS*ACC_WIDTH-1:0]  raw_im,
  input  logic signed [N_POLS*CORR_WIDTH-1:0] re_corr,
  input  logic signed [N_POLS*CORR_WIDTH-1:0] im_corr,
  output logic signed [N_POLS*OUT_WIDTH-1:0]  dout_re,
  output logic signed [N_POLS*OUT_WIDTH-1:0]  dout_im,
  output logic                                dout_vld,
  output logic                                sync_out,
  output logic [BL_W-1:0]                     bl_idx,
  output logic                                sat_flag
);

  logic              vld_p0, vld_p1, sync_p0, sync_p1;
  logic [N_POLS-1:0] lane_clamp;
  logic [BL_W-1:0]   nxt_idx, cur_idx;

  for (genvar g = 0; g < N_POLS; g++) begin : g_lane
    localparam int AB = lane_base(g, ACC_WIDTH);
    localparam int CB = lane_base(g, CORR_WIDTH);
    localparam int OB = lane_base(g, OUT_WIDTH);

    xeng_corr_apply_corr_lane #(
      .ACC_WIDTH  (ACC_WIDTH),
      .CORR_WIDTH (CORR_WIDTH),
      .OUT_WIDTH  (OUT_WIDTH),
      .K_SHIFT    (K_SHIFT),
      .RE_CONST   (RE_CONST)
    ) u_corr_lane (
      .clk     (clk),
      .rst     (rst),
      .en_p0   (din_vld),
      .en_p1   (vld_p0),
      .en_p2   (vld_p1),
      .raw_re  (raw_re[AB +: ACC_WIDTH]),
      .raw_im  (raw_im[AB +: ACC_WIDTH]),
      .re_corr (re_corr[CB +: CORR_WIDTH]),
      .im_corr (im_corr[CB +: CORR_WIDTH]),
      .dout_re (dout_re[OB +: OUT_WIDTH]),
      .dout_im (dout_im[OB +: OUT_WIDTH]),
      .clamp   (lane_clamp[g])
    );
  end

  // valid/sync delay line, aligned with the three lane stages
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0   <= 1'b0;
      vld_p1   <= 1'b0;
      dout_vld <= 1'b0;
      sync_p0  <= 1'b0;
      sync_p1  <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      vld_p0   <= din_vld;
      vld_p1   <= vld_p0;
      dout_vld <= vld_p1;
      sync_p0  <= sync_in;
      sync_p1  <= sync_p0;
      sync_out <= sync_p1;
    end
  end

  // nxt_idx is the index the next valid output will carry; a bare sync rewinds it.
  always_comb cur_idx = sync_p1 ? '0 : nxt_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      bl_idx   <= '0;
      nxt_idx  <= '0;
      sat_flag <= 1'b0;
    end else begin
      if (vld_p1) begin
        bl_idx  <= cur_idx;
        nxt_idx <= (cur_idx == BL_W'(N_BLS - 1)) ? '0 : cur_idx + BL_W'(1);
      end else if (sync_p1) begin
        nxt_idx <= '0;
      end
      sat_flag <= (sat_flag & ~sync_p1) | (vld_p1 & (|lane_clamp));
    end
  end

endmodule

// File: tb/tb_xeng_corr_apply.sv
// Randomised and directed bench for xeng_corr_apply against a cycle-delayed arithmetic model.
`timescale 1ns/1ps
module tb_xeng_corr_apply;

  localparam int     AW   = 32;
  localparam int     OW   = 32;
  localparam int     CW   = 2 + 7 + 4 + 3;
  localparam int     NB   = 32 * (32 / 2 + 1);
  localparam int     BLW  = $clog2(NB);
  localparam longint RE_C = -(longint'(1) << 15);
  localparam longint OMAX = (longint'(1) << (OW - 1)) - 1;
  localparam longint OMIN = -(longint'(1) << (OW - 1));

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, sync_in, din_vld;
  logic [4*AW-1:0] raw_re, raw_im;
  logic [4*CW-1:0] re_corr, im_corr;
  logic [4*OW-1:0] dout_re, dout_im;
  logic            dout_vld, sync_out, sat_flag;
  logic [BLW-1:0]  bl_idx;

  xeng_corr_apply dut (
    .clk      (clk),
    .rst      (rst),
    .sync_in  (sync_in),
    .din_vld  (din_vld),
    .raw_re   (raw_re),
    .raw_im   (raw_im),
    .re_corr  (re_corr),
    .im_corr  (im_corr),
    .dout_re  (dout_re),
    .dout_im  (dout_im),
    .dout_vld (dout_vld),
    .sync_out (sync_out),
    .bl_idx   (bl_idx),
    .sat_flag (sat_flag)
  );

  typedef struct {
    bit              rst_mark;
    bit              vld;
    bit              sync;
    logic [4*AW-1:0] rr, ri;
    logic [4*CW-1:0] cr, ci;
  } ent_t;

  ent_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  logic [4*OW-1:0] m_re = '0, m_im = '0;
  bit              m_vld = 0, m_sync = 0, m_sat = 0;
  int              m_idx = 0, m_nxt = 0;

  localparam logic [4*AW-1:0] W35_RR = {4{32'd32768}};
  localparam logic [4*AW-1:0] W35_RI = {4{32'd10}};
  localparam logic [4*CW-1:0] W35_CI = {4{16'd1}};
  localparam logic [4*AW-1:0] CLP_RR = {4{32'h7fffffff}};
  localparam logic [4*CW-1:0] CLP_CR = {4{16'h8000}};
  localparam logic [4*AW-1:0] NEG_RR = {4{32'h80000000}};
  localparam logic [4*CW-1:0] NEG_CR = {4{16'h7fff}};

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void sat_one(input longint v, output logic [OW-1:0] o, output bit c);
    longint lv;
    c = 0;
    lv = v;
    if (v > OMAX) begin lv = OMAX; c = 1; end
    if (v < OMIN) begin lv = OMIN; c = 1; end
    o = lv[OW-1:0];
  endfunction

  function automatic void calc(input ent_t e, output logic [4*OW-1:0] re,
                               output logic [4*OW-1:0] im, output bit cl);
    logic [AW-1:0] sr;
    logic [CW-1:0] sc;
    logic [OW-1:0] o;
    bit            c1;
    longint        v;
    cl = 0;
    re = '0;
    im = '0;
    for (int p = 0; p < 4; p++) begin
      sr = e.rr[p*AW +: AW];
      sc = e.cr[p*CW +: CW];
      v  = longint'($signed(sr)) - longint'($signed(sc)) * 8 + RE_C;
      sat_one(v, o, c1);
      re[p*OW +: OW] = o;
      cl |= c1;
      sr = e.ri[p*AW +: AW];
      sc = e.ci[p*CW +: CW];
      v  = longint'($signed(sr)) - longint'($signed(sc)) * 8;
      sat_one(v, o, c1);
      im[p*OW +: OW] = o;
      cl |= c1;
    end
  endfunction

  // One clock: check the output the model owes for this cycle, then apply new inputs.
  task automatic drive(input bit r, input bit v, input bit s,
                       input logic [4*AW-1:0] rr, input logic [4*AW-1:0] ri,
                       input logic [4*CW-1:0] cr, input logic [4*CW-1:0] ci);
    ent_t            e, n;
    logic [4*OW-1:0] xr, xi;
    bit              cl;
    @(negedge clk);
    if (q.size() == 3) begin
      e = q.pop_front();
      if (e.rst_mark) begin
        m_re = '0; m_im = '0; m_vld = 0; m_sync = 0; m_sat = 0; m_idx = 0; m_nxt = 0;
      end else begin
        m_vld  = e.vld;
        m_sync = e.sync;
        if (e.sync) m_sat = 0;
        if (e.vld) begin
          calc(e, xr, xi, cl);
          m_re = xr;
          m_im = xi;
          if (cl) m_sat = 1;
          m_idx = e.sync ? 0 : m_nxt;
          m_nxt = (m_idx + 1) % NB;
        end else if (e.sync) begin
          m_nxt = 0;
        end
      end
      chk("dout_vld", dout_vld, m_vld);
      chk("sync_out", sync_out, m_sync);
      chk("dout_re", dout_re, m_re);
      chk("dout_im", dout_im, m_im);
      chk("sat_flag", sat_flag, m_sat);
      if (m_vld || e.rst_mark) chk("bl_idx", bl_idx, m_idx);
    end
    rst = r; din_vld = v; sync_in = s;
    raw_re = rr; raw_im = ri; re_corr = cr; im_corr = ci;
    if (r) begin
      for (int i = 0; i < q.size(); i++) begin
        e = q[i];
        e.vld = 0;
        e.sync = 0;
        if (i == 0) e.rst_mark = 1;
        q[i] = e;
      end
    end
    n.rst_mark = 0;
    n.vld  = v & ~r;
    n.sync = s & ~r;
    n.rr = rr; n.ri = ri; n.cr = cr; n.ci = ci;
    q.push_back(n);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) drive(0, 0, 0, '0, '0, '0, '0);
  endtask

  function automatic logic [4*AW-1:0] rnd_acc();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [4*CW-1:0] rnd_corr();
    return {$urandom, $urandom};
  endfunction

  initial begin
    ent_t pre;
    rst = 1; sync_in = 0; din_vld = 0;
    raw_re = '0; raw_im = '0; re_corr = '0; im_corr = '0;
    pre.rst_mark = 0; pre.vld = 0; pre.sync = 0;
    pre.rr = '0; pre.ri = '0; pre.cr = '0; pre.ci = '0;
    q.push_back(pre);
    q.push_back(pre);

    for (int i = 0; i < 3; i++) drive(1, 0, 0, '0, '0, '0, '0);
    idle(3);
    chk("reset_re", dout_re, '0);
    chk("reset_sat", sat_flag, 1'b0);

    // directed offset/correction example
    drive(0, 1, 1, W35_RR, W35_RI, '0, W35_CI);
    idle(3);
    chk("ex_re", dout_re, {4{32'd0}});
    chk("ex_im", dout_im, {4{32'd2}});
    chk("ex_idx", bl_idx, 0);

    // back-to-back stream across two baseline wraps
    for (int i = 0; i < 2 * NB + 5; i++)
      drive(0, 1, i == 0, rnd_acc(), rnd_acc(), rnd_corr(), rnd_corr());
    idle(3);
    chk("stream_last_idx", bl_idx, 4);

    // positive clamp, then sync clears the sticky flag
    drive(0, 0, 1, '0, '0, '0, '0);
    drive(0, 1, 0, CLP_RR, '0, CLP_CR, '0);
    idle(3);
    chk("pos_clamp_re", dout_re, {4{32'h7fffffff}});
    chk("pos_clamp_sat", sat_flag, 1'b1);
    drive(0, 1, 1, W35_RR, W35_RI, '0, W35_CI);
    idle(3);
    chk("sync_clears_sat", sat_flag, 1'b0);

    // negative clamp
    drive(0, 1, 0, NEG_RR, '0, NEG_CR, '0);
    idle(3);
    chk("neg_clamp_re", dout_re, {4{32'h80000000}});
    chk("neg_clamp_sat", sat_flag, 1'b1);

    // clamp coincident with sync_out
    drive(0, 1, 1, CLP_RR, '0, CLP_CR, '0);
    idle(3);
    chk("clamp_with_sync_sat", sat_flag, 1'b1);
    chk("clamp_with_sync_idx", bl_idx, 0);

    // alternating valid
    for (int i = 0; i < 40; i++)
      drive(0, (i % 2) == 0, i == 0, rnd_acc(), rnd_acc(), rnd_corr(), rnd_corr());
    idle(3);

    // sync without valid rewinds the index
    for (int i = 0; i < 10; i++) drive(0, 1, 0, rnd_acc(), rnd_acc(), rnd_corr(), rnd_corr());
    drive(0, 0, 1, '0, '0, '0, '0);
    for (int i = 0; i < 5; i++) drive(0, 1, 0, rnd_acc(), rnd_acc(), rnd_corr(), rnd_corr());
    idle(3);
    chk("bare_sync_idx", bl_idx, 4);

    // reset with clamping words in flight, rst colliding with sync/valid
    drive(0, 1, 0, CLP_RR, '0, CLP_CR, '0);
    drive(0, 1, 0, CLP_RR, '0, CLP_CR, '0);
    drive(1, 1, 1, CLP_RR, '0, CLP_CR, '0);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("flushed_vld", dout_vld, 1'b0);
    end
    chk("flushed_idx", bl_idx, 0);
    chk("flushed_sat", sat_flag, 1'b0);
    chk("flushed_re", dout_re, '0);

    // index restarts from zero without a sync after reset
    for (int i = 0; i < 20; i++) drive(0, 1, 0, rnd_acc(), rnd_acc(), rnd_corr(), rnd_corr());
    idle(3);
    chk("post_reset_idx", bl_idx, 19);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
